rib_sram16_slave: RTL

RIB responder that terminates a 32-bit RIB master port on an external asynchronous 16-bit SRAM. Each 32-bit access becomes two halfword SRAM cycles (low half, then high half) with programmable wait states. Sits on the core's external-memory RIB port, or behind any slave-select port mapped to off-chip SRAM. It is the slave end of the same req/gnt/rsp/rdy handshake the core masters drive.

---
 rtl/rib_sram16_slave_pkg.sv | 26 ++
 rtl/rib_sram16_slave.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rib_sram16_slave_pkg.sv
// Shared RIB definitions: responder state encoding, wrcs encoding and request capture type.
// No logic; no latency; no backpressure.
// Imported by RIB slaves that terminate a master port on external memory.
package rib_sram16_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RSP  = 2'd3
  } rib_sram_state_e;

  localparam logic RIB_WRCS_WR = 1'b1;

  typedef struct packed {
    logic        wrcs;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } rib_req_t;

  // Byte enables of the halfword addressed in the given phase.
  function automatic logic [1:0] lane_mask(input logic [3:0] mask, input logic hi);
    return hi ? mask[3:2] : mask[1:0];
  endfunction

endpackage

// File: rtl/rib_sram16_slave.sv
// RIB slave terminating 32-bit accesses on an async 16-bit SRAM as two halfword cycles.
// Latency: read/full write 2*(WAIT_CYCLES+1)+1, half write WAIT_CYCLES+2, empty-mask write 1.
// Backpressure: rsp/rdata held until i_ribs_rdy; gnt low whenever a transaction is in flight.
module rib_sram16_slave
  import rib_sram16_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_ribs_addr,
  input  logic              i_ribs_wrcs,
  input  logic [3:0]        i_ribs_mask,
  input  logic [31:0]       i_ribs_wdata,
  output logic [31:0]       o_ribs_rdata,
  input  logic              i_ribs_req,
  output logic              o_ribs_gnt,
  output logic              o_ribs_rsp,
  input  logic              i_ribs_rdy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_dq_o,
  output logic              o_sram_dq_oe,
  input  logic [15:0]       i_sram_dq_i,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [3:0] CAP_CNT   = 4'(WAIT_CYCLES - 1);

  rib_sram_state_e    state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-2:0]  haddr_q, haddr_d;
  rib_req_t           req_q, req_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               wr_in, wr_q, wr_d;
  logic               unused_addr;

  assign wr_in = (i_ribs_wrcs == RIB_WRCS_WR);
  assign wr_q  = (req_q.wrcs == RIB_WRCS_WR);
  assign wr_d  = (req_d.wrcs == RIB_WRCS_WR);
  assign unused_addr = ^{i_ribs_addr[31:ADDR_W+1], i_ribs_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    haddr_d = haddr_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (i_ribs_req) begin
          haddr_d = i_ribs_addr[ADDR_W:2];
          req_d   = '{wrcs: i_ribs_wrcs, mask: i_ribs_mask, wdata: i_ribs_wdata};
          rdata_d = '0;
          cnt_d   = '0;
          if (!wr_in)                            state_d = LO;
          else if (i_ribs_mask == 4'b0000)       state_d = RSP;
          else if (lane_mask(i_ribs_mask, 1'b0) == 2'b00) state_d = HI;
          else                                   state_d = LO;
        end
      end
      LO: begin
        if (!wr_q && cnt_q == CAP_CNT) rdata_d[15:0] = i_sram_dq_i;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = (wr_q && lane_mask(req_q.mask, 1'b1) == 2'b00) ? RSP : HI;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (!wr_q && cnt_q == CAP_CNT) rdata_d[31:16] = i_sram_dq_i;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RSP: begin
        if (i_ribs_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are decoded from next state and registered so strobes leave the block glitch-free.
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [15:0]       dq_d, dq_q;
  logic              dq_oe_d, dq_oe_q;
  logic              ce_n_d, ce_n_q, oe_n_d, oe_n_q, we_n_d, we_n_q;
  logic              ub_n_d, ub_n_q, lb_n_d, lb_n_q;
  logic              in_phase, strobe, hi_d;
  logic [1:0]        lanes_d;

  always_comb begin
    in_phase = (state_d == LO) || (state_d == HI);
    hi_d     = (state_d == HI);
    strobe   = in_phase && (cnt_d != WAIT_LAST);
    lanes_d  = lane_mask(req_d.mask, hi_d);
    addr_d   = '0;
    dq_d     = '0;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    if (in_phase) begin
      addr_d = {haddr_d, hi_d};
      ce_n_d = ~strobe;
      if (wr_d) begin
        dq_d    = hi_d ? req_d.wdata[31:16] : req_d.wdata[15:0];
        dq_oe_d = 1'b1;
        we_n_d  = ~strobe;
        ub_n_d  = ~lanes_d[1];
        lb_n_d  = ~lanes_d[0];
      end else begin
        oe_n_d = ~strobe;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      haddr_q <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      haddr_q <= haddr_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  assign o_ribs_gnt   = (state_q == IDLE);
  assign o_ribs_rsp   = (state_q == RSP);
  assign o_ribs_rdata = (state_q == RSP) ? rdata_q : 32'h0;
  assign o_sram_addr  = addr_q;
  assign o_sram_dq_o  = dq_q;
  assign o_sram_dq_oe = dq_oe_q;
  assign o_sram_ce_n  = ce_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_ub_n  = ub_n_q;
  assign o_sram_lb_n  = lb_n_q;

endmodule
